// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared widths and state encoding for the SRAM bus arbiter
package sram_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int TYPE_W = 6;
  localparam int LINE_W = 256;
  localparam int STRB_W = 16;
  localparam int TMO_W  = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    RD_RSP = 2'd2,
    WR_REQ = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sram_bus_arbiter_rr_pick.sv
// rtl/sram_bus_arbiter_rr_pick.sv - combinational round-robin picker (rr_pick)
// Picks the first requester strictly after ptr, wrapping explicitly at N-1.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      // explicit modulo: N need not be a power of two
      if (cand >= N) cand = cand - N;
      if (!valid && req[IW'(cand)]) begin
        valid              = 1'b1;
        idx                = IW'(cand);
        grant[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - serialises NUM_M SRAM-style masters onto one downstream bus
// Optional watchdog enabled by SRAM_ARB_TIMEOUT_EN.
module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int NUM_M   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_r_req,
  input  logic [NUM_M*ADDR_W-1:0]   m_r_addr,
  input  logic [NUM_M*TYPE_W-1:0]   m_r_type,
  output logic [NUM_M-1:0]          m_r_rdy,
  output logic [LINE_W-1:0]         m_re_data,
  output logic [NUM_M-1:0]          m_re_valid,
  input  logic [NUM_M-1:0]          m_w_req,
  input  logic [NUM_M*ADDR_W-1:0]   m_w_addr,
  input  logic [NUM_M*TYPE_W-1:0]   m_w_type,
  input  logic [NUM_M*LINE_W-1:0]   m_w_data,
  input  logic [NUM_M*STRB_W-1:0]   m_w_strb,
  output logic [NUM_M-1:0]          m_w_rdy,
  output logic                      s_r_req,
  output logic [ADDR_W-1:0]         s_r_addr,
  output logic [TYPE_W-1:0]         s_r_type,
  input  logic                      s_r_rdy,
  input  logic [LINE_W-1:0]         s_re_data,
  input  logic                      s_re_valid,
  output logic                      s_w_req,
  output logic [ADDR_W-1:0]         s_w_addr,
  output logic [TYPE_W-1:0]         s_w_type,
  output logic [LINE_W-1:0]         s_w_data,
  output logic [STRB_W-1:0]         s_w_strb,
  input  logic                      s_w_rdy,
  output logic                      err
);

  localparam int IW = $clog2(NUM_M);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RD_REQ = RD_REQ;
  localparam logic [1:0] S_RD_RSP = RD_RSP;
  localparam logic [1:0] S_WR_REQ = WR_REQ;

  logic [1:0]        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [TYPE_W-1:0] type_q;
  logic [LINE_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;

  logic [NUM_M-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic              pick_is_wr;
  logic              tmo_hit;
  logic              rd_tmo;
  logic              wr_tmo;

  rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
    .req   (m_w_req | m_r_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // a master's pending write beats its own read so writebacks precede refills
  assign pick_is_wr = |(pick_grant & m_w_req);

  // forward progress always wins over a watchdog expiry in the same cycle
  assign rd_tmo = tmo_hit && ((state == S_RD_REQ && !s_r_rdy) ||
                              (state == S_RD_RSP && !s_re_valid));
  assign wr_tmo = tmo_hit && (state == S_WR_REQ) && !s_w_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= IW'(NUM_M - 1);
      gnt    <= '0;
      addr_q <= '0;
      type_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt <= pick_idx;
            ptr <= pick_idx;
            if (pick_is_wr) begin
              state  <= S_WR_REQ;
              addr_q <= m_w_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
              type_q <= m_w_type[int'(pick_idx)*TYPE_W +: TYPE_W];
              data_q <= m_w_data[int'(pick_idx)*LINE_W +: LINE_W];
              strb_q <= m_w_strb[int'(pick_idx)*STRB_W +: STRB_W];
            end else begin
              state  <= S_RD_REQ;
              addr_q <= m_r_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
              type_q <= m_r_type[int'(pick_idx)*TYPE_W +: TYPE_W];
            end
          end
        end
        S_RD_REQ: begin
          if (s_r_rdy)     state <= S_RD_RSP;
          else if (rd_tmo) state <= S_IDLE;
        end
        S_RD_RSP: if (s_re_valid || rd_tmo) state <= S_IDLE;
        S_WR_REQ: if (s_w_rdy || wr_tmo) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign s_r_req  = (state == S_RD_REQ);
  assign s_r_addr = addr_q;
  assign s_r_type = type_q;
  assign s_w_req  = (state == S_WR_REQ);
  assign s_w_addr = addr_q;
  assign s_w_type = type_q;
  assign s_w_data = data_q;
  assign s_w_strb = strb_q;

  always_comb begin
    m_r_rdy    = '0;
    m_w_rdy    = '0;
    m_re_valid = '0;
    m_re_data  = '0;
    if (state == S_RD_REQ && (s_r_rdy || rd_tmo)) m_r_rdy[gnt] = 1'b1;
    if (state == S_RD_RSP && s_re_valid) begin
      m_re_valid[gnt] = 1'b1;
      m_re_data       = s_re_data;
    end else if (rd_tmo) begin
      m_re_valid[gnt] = 1'b1;
    end
    if (state == S_WR_REQ && (s_w_rdy || wr_tmo)) m_w_rdy[gnt] = 1'b1;
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE || (state == S_RD_REQ && s_r_rdy)) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      if (rd_tmo || wr_tmo) err_q <= 1'b1;
    end
  end

  assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign err     = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
